// File: rtl/i2c_slave_fsm.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write bytes to a consumer and read bytes from a producer via a holding register.
module i2c_slave_fsm #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i2c_core_clk_i,
    input  logic       reset_i,
    input  logic       i2c_scl_i,
    input  logic       i2c_sda_i,
    output logic       sda_low_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_full_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o,
    output logic       busy_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(7);
    localparam logic [BYTE_W-1:0] IDLE_BYTE = BYTE_W'(8'hFF);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX_DATA   = 3'd3,
        RX_ACK    = 3'd4,
        TX_DATA   = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;

    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              byte_done, byte_done_nxt;
    logic [BYTE_W-1:0] shift_in, shift_in_nxt;
    logic [BYTE_W-1:0] tx_shift, tx_shift_nxt;
    logic              rw, rw_nxt;
    logic              ack_ok, ack_ok_nxt;
    logic [BYTE_W-1:0] hold_data, hold_data_nxt;
    logic              hold_empty, hold_empty_nxt;
    logic              sda_low_nxt;
    logic [BYTE_W-1:0] rx_data_nxt;
    logic              rx_valid_nxt, underrun_nxt, busy_nxt;
    logic              load_tx, fill;
    logic [BYTE_W-1:0] load_byte;
    logic              addr_match;

    // Synchronizers preset to 1 so reset looks like an idle bus
    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign sda_rise  = sda_s & ~sda_q;
    assign sda_fall  = ~sda_s & sda_q;
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    assign addr_match = (shift_in[7:1] == SLAVE_ADDR);
    assign load_byte  = hold_empty ? IDLE_BYTE : hold_data;
    assign tx_ready_o = hold_empty;

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_fall && byte_done) begin
                        state_next = addr_match ? ADDR_ACK : WAIT_STOP;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_next = rw ? TX_DATA : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (scl_fall && byte_done) begin
                        state_next = rx_full_i ? WAIT_STOP : RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_next = RX_DATA;
                    end
                end
                TX_DATA: begin
                    if (scl_fall && byte_done) begin
                        state_next = TX_ACK;
                    end
                end
                TX_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_next = WAIT_STOP;
                    end else if (scl_fall && ack_ok) begin
                        state_next = TX_DATA;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        byte_done_nxt = byte_done;
        shift_in_nxt  = shift_in;
        tx_shift_nxt  = tx_shift;
        rw_nxt        = rw;
        ack_ok_nxt    = ack_ok;
        sda_low_nxt   = sda_low_en_o;
        rx_data_nxt   = rx_data_o;
        rx_valid_nxt  = 1'b0;
        underrun_nxt  = 1'b0;
        load_tx       = 1'b0;

        if (stop_det) begin
            sda_low_nxt = 1'b0;
            ack_ok_nxt  = 1'b0;
        end else if (start_det) begin
            bit_cnt_nxt   = CNT_TOP;
            byte_done_nxt = 1'b0;
            ack_ok_nxt    = 1'b0;
            sda_low_nxt   = 1'b0;
        end else begin
            case (state)
                ADDR, RX_DATA: begin
                    if (scl_rise) begin
                        shift_in_nxt  = {shift_in[BYTE_W-2:0], sda_s};
                        bit_cnt_nxt   = bit_cnt - CNT_W'(1);
                        byte_done_nxt = (bit_cnt == '0);
                    end else if (scl_fall && byte_done) begin
                        byte_done_nxt = 1'b0;
                        sda_low_nxt   = 1'b0;
                        if (state == ADDR) begin
                            if (addr_match) begin
                                rw_nxt      = shift_in[0];
                                sda_low_nxt = 1'b1;
                            end
                        end else if (!rx_full_i) begin
                            rx_data_nxt  = shift_in;
                            rx_valid_nxt = 1'b1;
                            sda_low_nxt  = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt = 1'b0;
                        if (rw) begin
                            load_tx      = 1'b1;
                            tx_shift_nxt = load_byte;
                            sda_low_nxt  = ~load_byte[BYTE_W-1];
                            underrun_nxt = hold_empty;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_low_nxt = 1'b0;
                    end
                end
                TX_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt   = bit_cnt - CNT_W'(1);
                        byte_done_nxt = (bit_cnt == '0);
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            byte_done_nxt = 1'b0;
                            sda_low_nxt   = 1'b0;
                        end else begin
                            // Counter already points at the next bit to present
                            sda_low_nxt = ~tx_shift[bit_cnt];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        ack_ok_nxt = ~sda_s;
                    end else if (scl_fall && ack_ok) begin
                        ack_ok_nxt   = 1'b0;
                        load_tx      = 1'b1;
                        tx_shift_nxt = load_byte;
                        sda_low_nxt  = ~load_byte[BYTE_W-1];
                        underrun_nxt = hold_empty;
                    end
                end
                default: sda_low_nxt = 1'b0;
            endcase
        end

        // A fill in the same cycle as a load keeps the new byte
        fill           = tx_valid_i & hold_empty;
        hold_data_nxt  = fill ? tx_data_i : hold_data;
        hold_empty_nxt = fill ? 1'b0 : (load_tx ? 1'b1 : hold_empty);
        busy_nxt       = (state_next != IDLE);
    end

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            bit_cnt       <= CNT_TOP;
            byte_done     <= 1'b0;
            shift_in      <= '0;
            tx_shift      <= '0;
            rw            <= 1'b0;
            ack_ok        <= 1'b0;
            hold_data     <= '0;
            hold_empty    <= 1'b1;
            sda_low_en_o  <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            bit_cnt       <= bit_cnt_nxt;
            byte_done     <= byte_done_nxt;
            shift_in      <= shift_in_nxt;
            tx_shift      <= tx_shift_nxt;
            rw            <= rw_nxt;
            ack_ok        <= ack_ok_nxt;
            hold_data     <= hold_data_nxt;
            hold_empty    <= hold_empty_nxt;
            sda_low_en_o  <= sda_low_nxt;
            rx_data_o     <= rx_data_nxt;
            rx_valid_o    <= rx_valid_nxt;
            tx_underrun_o <= underrun_nxt;
            busy_o        <= busy_nxt;
        end
    end

endmodule
